simd_addsub_pipe: RTL and testbench

Pipelined, parametrised packed-SIMD adder/subtractor, successor to the combinational full_adder. Operands split into 32/16/8-bit lanes, per the existing SIZE encoding. Adds optional saturation (signed or unsigned), per-lane carry/overflow flags and a valid/ready stream interface. It sits in the ALU datapath between operand fetch and writeback.

---
 rtl/simd_addsub_pipe.sv | 264 ++++++++++++++++++++++++++
 tb/tb_simd_addsub_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_addsub_pipe.sv
// -----------------------------------------------------------------------------
// simd_addsub_pipe
//
// Two-stage packed-SIMD adder/subtractor with optional signed or unsigned
// saturation and per-lane carry/borrow and signed-overflow flags. Each 32-bit
// word of the operands is split into one 32-bit, two 16-bit or four 8-bit
// lanes, and no carry ever crosses a lane boundary.
//
// Stage 1 registers the per-byte 9-bit sums (carry chain gated by lane size).
// Stage 2 registers the saturated result and the flags.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   SA_FLUSH_i      synchronous clear of both in-flight stages
//   SA_VALID_i      input operation valid
//   SA_READY_o      an operation can be accepted this cycle (combinational)
//   SA_A_i, SA_B_i  packed operands
//   SA_SIZE_i       00/11 = 32-bit lanes, 01 = 16-bit, 10 = 8-bit
//   SA_OP_i         0 = A+B, 1 = A-B
//   SA_SAT_i        1 = saturate the lane result
//   SA_SIGNED_i     saturation mode: 1 = signed, 0 = unsigned
//   SA_VALID_o      result valid
//   SA_READY_i      downstream accepts the result
//   SA_R_o          packed result
//   SA_CARRY_o      carry (add) / borrow (sub), on each lane's top byte bit
//   SA_OVF_o        signed overflow, on each lane's top byte bit
// -----------------------------------------------------------------------------
module simd_addsub_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NBYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SA_FLUSH_i,
    input  logic                  SA_VALID_i,
    output logic                  SA_READY_o,
    input  logic [DATA_WIDTH-1:0] SA_A_i,
    input  logic [DATA_WIDTH-1:0] SA_B_i,
    input  logic [1:0]            SA_SIZE_i,
    input  logic                  SA_OP_i,
    input  logic                  SA_SAT_i,
    input  logic                  SA_SIGNED_i,
    output logic                  SA_VALID_o,
    input  logic                  SA_READY_i,
    output logic [DATA_WIDTH-1:0] SA_R_o,
    output logic [NBYTES-1:0]     SA_CARRY_o,
    output logic [NBYTES-1:0]     SA_OVF_o
);

    // True when byte idx is the least significant byte of its lane.
    function automatic logic lane_lsb(input int idx, input logic [1:0] size);
        logic r;
        case (size)
            2'b01:   r = ((idx % 32'sd2) == 32'sd0);
            2'b10:   r = 1'b1;
            default: r = ((idx % 32'sd4) == 32'sd0);
        endcase
        return r;
    endfunction

    // Index of the most significant byte of the lane containing byte idx.
    function automatic int lane_msb(input int idx, input logic [1:0] size);
        int r;
        case (size)
            2'b01:   r = idx | 32'sd1;
            2'b10:   r = idx;
            default: r = idx | 32'sd3;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_advance_s;
    logic ready_s;
    logic accept_s;

    // Stage 1 may move on whenever stage 2 is empty or is being consumed.
    assign s1_advance_s = !s2_valid_q || SA_READY_i;
    assign ready_s      = !SA_FLUSH_i && (!s1_valid_q || s1_advance_s);
    assign accept_s     = SA_VALID_i && ready_s;
    assign SA_READY_o   = ready_s;

    // ------------------------------------------------------------ stage 1 logic
    logic [NBYTES-1:0][8:0] sum_s;
    logic [NBYTES-1:0]      a_sign_s;
    logic [NBYTES-1:0]      b_sign_s;

    // Per-byte sums; the carry between bytes is replaced by the lane's carry-in
    // (OP, i.e. the +1 of A + ~B + 1) at every lane LSB.
    always_comb begin
        logic       cy;
        logic [7:0] a_b;
        logic [7:0] b_b;
        cy       = 1'b0;
        a_b      = 8'h00;
        b_b      = 8'h00;
        sum_s    = '0;
        a_sign_s = '0;
        b_sign_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            a_b         = SA_A_i[i*8 +: 8];
            b_b         = SA_OP_i ? ~SA_B_i[i*8 +: 8] : SA_B_i[i*8 +: 8];
            cy          = lane_lsb(i, SA_SIZE_i) ? SA_OP_i : cy;
            sum_s[i]    = {1'b0, a_b} + {1'b0, b_b} + {8'h00, cy};
            cy          = sum_s[i][8];
            a_sign_s[i] = a_b[7];
            b_sign_s[i] = b_b[7];
        end
    end

    logic [NBYTES-1:0][8:0] s1_sum_q,    s1_sum_d;
    logic [NBYTES-1:0]      s1_a_sign_q, s1_a_sign_d;
    logic [NBYTES-1:0]      s1_b_sign_q, s1_b_sign_d;
    logic [1:0]             s1_size_q,   s1_size_d;
    logic                   s1_op_q,     s1_op_d;
    logic                   s1_sat_q,    s1_sat_d;
    logic                   s1_signed_q, s1_signed_d;

    // Stage 1 next state: capture on accept, flush wins over everything.
    always_comb begin
        s1_sum_d    = s1_sum_q;
        s1_a_sign_d = s1_a_sign_q;
        s1_b_sign_d = s1_b_sign_q;
        s1_size_d   = s1_size_q;
        s1_op_d     = s1_op_q;
        s1_sat_d    = s1_sat_q;
        s1_signed_d = s1_signed_q;
        if (accept_s) begin
            s1_sum_d    = sum_s;
            s1_a_sign_d = a_sign_s;
            s1_b_sign_d = b_sign_s;
            s1_size_d   = SA_SIZE_i;
            s1_op_d     = SA_OP_i;
            s1_sat_d    = SA_SAT_i;
            s1_signed_d = SA_SIGNED_i;
        end else begin
            s1_sum_d    = s1_sum_q;
        end
        if (SA_FLUSH_i) begin
            s1_valid_d = 1'b0;
        end else if (accept_s) begin
            s1_valid_d = 1'b1;
        end else if (s1_advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_a_sign_q <= '0;
            s1_b_sign_q <= '0;
            s1_size_q   <= 2'b00;
            s1_op_q     <= 1'b0;
            s1_sat_q    <= 1'b0;
            s1_signed_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_a_sign_q <= s1_a_sign_d;
            s1_b_sign_q <= s1_b_sign_d;
            s1_size_q   <= s1_size_d;
            s1_op_q     <= s1_op_d;
            s1_sat_q    <= s1_sat_d;
            s1_signed_q <= s1_signed_d;
        end
    end

    // ------------------------------------------------------------ stage 2 logic
    logic [NBYTES-1:0]     carry_s;
    logic [NBYTES-1:0]     ovf_s;
    logic [DATA_WIDTH-1:0] res_s;

    // Flags live on each lane's top byte: the carry-out of a subtract is the
    // inverse of the borrow, and overflow is "same operand signs, different
    // result sign" using the inverted B that was actually added.
    always_comb begin
        carry_s = '0;
        ovf_s   = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane_msb(i, s1_size_q) == i) begin
                carry_s[i] = s1_sum_q[i][8] ^ s1_op_q;
                ovf_s[i]   = (s1_a_sign_q[i] == s1_b_sign_q[i]) &&
                             (s1_sum_q[i][7] != s1_a_sign_q[i]);
            end else begin
                carry_s[i] = 1'b0;
                ovf_s[i]   = 1'b0;
            end
        end
    end

    // Saturation replaces every byte of a lane using that lane's top-byte flags.
    always_comb begin
        int m;
        m     = 0;
        res_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            m = lane_msb(i, s1_size_q);
            if (s1_sat_q && s1_signed_q && ovf_s[m]) begin
                if (i == m) begin
                    res_s[i*8 +: 8] = s1_a_sign_q[m] ? 8'h80 : 8'h7F;
                end else begin
                    res_s[i*8 +: 8] = s1_a_sign_q[m] ? 8'h00 : 8'hFF;
                end
            end else if (s1_sat_q && !s1_signed_q && carry_s[m]) begin
                res_s[i*8 +: 8] = s1_op_q ? 8'h00 : 8'hFF;
            end else begin
                res_s[i*8 +: 8] = s1_sum_q[i][7:0];
            end
        end
    end

    logic [DATA_WIDTH-1:0] s2_r_q,     s2_r_d;
    logic [NBYTES-1:0]     s2_carry_q, s2_carry_d;
    logic [NBYTES-1:0]     s2_ovf_q,   s2_ovf_d;

    // Stage 2 next state: load from stage 1 when it advances, otherwise hold.
    always_comb begin
        s2_r_d     = s2_r_q;
        s2_carry_d = s2_carry_q;
        s2_ovf_d   = s2_ovf_q;
        if (s1_advance_s && s1_valid_q) begin
            s2_r_d     = res_s;
            s2_carry_d = carry_s;
            s2_ovf_d   = ovf_s;
        end else begin
            s2_r_d     = s2_r_q;
        end
        if (SA_FLUSH_i) begin
            s2_valid_d = 1'b0;
        end else if (s1_advance_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_r_q     <= '0;
            s2_carry_q <= '0;
            s2_ovf_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_r_q     <= s2_r_d;
            s2_carry_q <= s2_carry_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign SA_VALID_o = s2_valid_q;
    assign SA_R_o     = s2_r_q;
    assign SA_CARRY_o = s2_carry_q;
    assign SA_OVF_o   = s2_ovf_q;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_addsub_pipe
//
// Self-checking bench for simd_addsub_pipe at DATA_WIDTH=64 (two packed words).
// A lane-level arithmetic model plus an in-order queue of in-flight ops gives
// the expected valid/ready/result/flags every cycle; directed vectors pin the
// model with literal values.
// -----------------------------------------------------------------------------
module tb_simd_addsub_pipe;
    localparam int DW = 64;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SA_FLUSH_i  = 1'b0;
    logic          SA_VALID_i  = 1'b0;
    logic          SA_READY_o;
    logic [DW-1:0] SA_A_i      = '0;
    logic [DW-1:0] SA_B_i      = '0;
    logic [1:0]    SA_SIZE_i   = 2'b00;
    logic          SA_OP_i     = 1'b0;
    logic          SA_SAT_i    = 1'b0;
    logic          SA_SIGNED_i = 1'b0;
    logic          SA_VALID_o;
    logic          SA_READY_i  = 1'b1;
    logic [DW-1:0] SA_R_o;
    logic [NB-1:0] SA_CARRY_o;
    logic [NB-1:0] SA_OVF_o;

    simd_addsub_pipe #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SA_FLUSH_i (SA_FLUSH_i),
        .SA_VALID_i (SA_VALID_i),
        .SA_READY_o (SA_READY_o),
        .SA_A_i     (SA_A_i),
        .SA_B_i     (SA_B_i),
        .SA_SIZE_i  (SA_SIZE_i),
        .SA_OP_i    (SA_OP_i),
        .SA_SAT_i   (SA_SAT_i),
        .SA_SIGNED_i(SA_SIGNED_i),
        .SA_VALID_o (SA_VALID_o),
        .SA_READY_i (SA_READY_i),
        .SA_R_o     (SA_R_o),
        .SA_CARRY_o (SA_CARRY_o),
        .SA_OVF_o   (SA_OVF_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Lane-by-lane arithmetic reference using plain integers.
    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [1:0] size, input logic op,
                                  input logic sat, input logic sgn,
                                  output logic [DW-1:0] r, output logic [NB-1:0] c,
                                  output logic [NB-1:0] o);
        int                lw;
        longint unsigned   mask, av, bv, res;
        longint            sa, sb, sr, smax, smin;
        logic              cy, ov;
        logic [DW-1:0]     ta, tb, tr;
        lw   = (size == 2'd1) ? 16 : (size == 2'd2) ? 8 : 32;
        mask = (64'd1 << lw) - 64'd1;
        smax = longint'(mask >> 1);
        smin = -smax - 64'sd1;
        r = '0; c = '0; o = '0;
        for (int lo = 0; lo < DW; lo += lw) begin
            ta = a >> lo;
            tb = b >> lo;
            av = {32'd0, ta[31:0]} & mask;
            bv = {32'd0, tb[31:0]} & mask;
            sa = (av > (mask >> 1)) ? longint'(av - mask - 64'd1) : longint'(av);
            sb = (bv > (mask >> 1)) ? longint'(bv - mask - 64'd1) : longint'(bv);
            if (!op) begin
                res = av + bv;
                cy  = res[lw];
                sr  = sa + sb;
            end else begin
                res = av - bv;
                cy  = (av < bv);
                sr  = sa - sb;
            end
            res = res & mask;
            ov  = (sr > smax) || (sr < smin);
            if (sat && sgn && ov) res = (sa < 0) ? (mask >> 1) + 64'd1 : (mask >> 1);
            if (sat && !sgn && cy) res = op ? 64'd0 : mask;
            tr = DW'(res);
            r  = r | (tr << lo);
            c[(lo + lw) / 8 - 1] = cy;
            o[(lo + lw) / 8 - 1] = ov;
        end
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NB; i++) begin
            case ($urandom_range(0, 4))
                0:       w[i*8 +: 8] = 8'h00;
                1:       w[i*8 +: 8] = 8'h7F;
                2:       w[i*8 +: 8] = 8'h80;
                3:       w[i*8 +: 8] = 8'hFF;
                default: w[i*8 +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [DW-1:0] r;
        logic [NB-1:0] c;
        logic [NB-1:0] o;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;

    // Compare process: sampled on the falling edge, inputs settled since #1.
    always @(negedge clk) begin
        exp_t          e;
        logic          exp_valid, exp_ready;
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            exp_ready = !SA_FLUSH_i && ((q.size() < 2) || SA_READY_i);
            chk("valid_o", DW'(SA_VALID_o), DW'(exp_valid));
            chk("ready_o", DW'(SA_READY_o), DW'(exp_ready));
            if (SA_VALID_o && exp_valid) begin
                chk("result", SA_R_o, q[0].r);
                chk("carry", DW'(SA_CARRY_o), DW'(q[0].c));
                chk("ovf", DW'(SA_OVF_o), DW'(q[0].o));
            end
            if (SA_VALID_o && SA_READY_i && q.size() > 0) void'(q.pop_front());
            if (SA_FLUSH_i) q.delete();
            if (SA_VALID_i && SA_READY_o) begin
                model(SA_A_i, SA_B_i, SA_SIZE_i, SA_OP_i, SA_SAT_i, SA_SIGNED_i, e.r, e.c, e.o);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Present an op and wait (bounded) until it is accepted; returns at edge+1.
    task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [1:0] size, input logic op,
                            input logic sat, input logic sgn);
        logic acc;
        acc = 1'b0;
        SA_VALID_i = 1'b1; SA_A_i = a; SA_B_i = b; SA_SIZE_i = size;
        SA_OP_i = op; SA_SAT_i = sat; SA_SIGNED_i = sgn;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (SA_READY_o) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got ready_o=0 for 50 cycles, want 1");
        end
        @(posedge clk); #1;
    endtask

    // Directed vector: pins the model, then checks the DUT with literal values
    // (the 32-bit vector replicated in both words) and exact latency.
    task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] size, input logic op, input logic sat,
                       input logic sgn, input logic [31:0] er, input logic [3:0] ec,
                       input logic [3:0] eo);
        logic [DW-1:0] mr;
        logic [NB-1:0] mc, mo;
        model({a, a}, {b, b}, size, op, sat, sgn, mr, mc, mo);
        chk({nm, "_model_r"}, mr, {er, er});
        chk({nm, "_model_c"}, DW'(mc), DW'({ec, ec}));
        chk({nm, "_model_o"}, DW'(mo), DW'({eo, eo}));
        SA_READY_i = 1'b1;
        drive_op({a, a}, {b, b}, size, op, sat, sgn);
        SA_VALID_i = 1'b0;
        chk({nm, "_lat1"}, DW'(SA_VALID_o), DW'(1'b0));
        @(posedge clk); #1;
        chk({nm, "_lat2"}, DW'(SA_VALID_o), DW'(1'b1));
        chk({nm, "_r"}, SA_R_o, {er, er});
        chk({nm, "_c"}, DW'(SA_CARRY_o), DW'({ec, ec}));
        chk({nm, "_o"}, DW'(SA_OVF_o), DW'({eo, eo}));
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(SA_VALID_o), DW'(1'b0));
        chk("rst_r", SA_R_o, '0);
        chk("rst_c", DW'(SA_CARRY_o), '0);
        chk("rst_o", DW'(SA_OVF_o), '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        dir("iso32",   32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b1000, 4'b0000);
        dir("wrap8",   32'hFFFFFFFF, 32'h00000001, 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFFFF00, 4'b0001, 4'b0000);
        dir("usub8",   32'h12345678, 32'h87654321, 2'b10, 1'b1, 1'b1, 1'b0, 32'h00001357, 4'b1100, 4'b1000);
        dir("ssat16",  32'h7FFF8000, 32'h00018000, 2'b01, 1'b0, 1'b1, 1'b1, 32'h7FFF8000, 4'b0010, 4'b1010);
        dir("swrap16", 32'h7FFF8000, 32'h00018000, 2'b01, 1'b0, 1'b0, 1'b1, 32'h80000000, 4'b0010, 4'b1010);
        dir("size11",  32'h00000000, 32'h00000001, 2'b11, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b1000, 4'b0000);
        dir("ssub8",   32'h80808080, 32'h01010101, 2'b10, 1'b1, 1'b1, 1'b1, 32'h80808080, 4'b0000, 4'b1111);

        // Backpressure: four back-to-back ops, downstream stalled for 5 cycles.
        SA_READY_i = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 chk("bp_ready_low", DW'(SA_READY_o), DW'(1'b0));
                repeat (2) @(posedge clk);
                #1 SA_READY_i = 1'b1;
            end
            begin
                for (int k = 0; k < 4; k++)
                    drive_op(rand_word(), rand_word(), 2'($urandom_range(0, 3)),
                             1'($urandom), 1'($urandom), 1'($urandom));
                SA_VALID_i = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("bp_drained", DW'(q.size()), '0);

        // Flush with two ops in flight: nothing may ever emerge.
        SA_READY_i = 1'b0;
        drive_op(64'h0102030405060708, 64'h1111111111111111, 2'b10, 1'b0, 1'b0, 1'b0);
        drive_op(64'h8000000080000000, 64'h0000000100000001, 2'b00, 1'b1, 1'b1, 1'b1);
        SA_VALID_i = 1'b0;
        chk("fl_pre_valid", DW'(SA_VALID_o), DW'(1'b1));
        SA_FLUSH_i = 1'b1;
        @(posedge clk); #1;
        SA_FLUSH_i = 1'b0;
        chk("fl_valid", DW'(SA_VALID_o), DW'(1'b0));
        SA_READY_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("fl_no_result", DW'(SA_VALID_o), DW'(1'b0));

        // Asynchronous reset mid-cycle with two ops in flight.
        SA_READY_i = 1'b0;
        drive_op(64'h1111111111111111, 64'h2222222222222222, 2'b00, 1'b0, 1'b0, 1'b0);
        drive_op(64'h3333333333333333, 64'h4444444444444444, 2'b01, 1'b0, 1'b0, 1'b0);
        SA_VALID_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", DW'(SA_VALID_o), DW'(1'b0));
        chk("ar_r", SA_R_o, '0);
        chk("ar_c", DW'(SA_CARRY_o), '0);
        chk("ar_o", DW'(SA_OVF_o), '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        SA_READY_i = 1'b1;
        @(posedge clk); #1;
        dir("post_rst", 32'h12345678, 32'h87654321, 2'b10, 1'b1, 1'b1, 1'b0, 32'h00001357, 4'b1100, 4'b1000);

        // Randomised traffic with random backpressure and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            SA_VALID_i  = ($urandom_range(0, 3) != 0);
            SA_A_i      = rand_word();
            SA_B_i      = rand_word();
            SA_SIZE_i   = 2'($urandom_range(0, 3));
            SA_OP_i     = 1'($urandom);
            SA_SAT_i    = 1'($urandom);
            SA_SIGNED_i = 1'($urandom);
            SA_READY_i  = ($urandom_range(0, 3) != 0);
            SA_FLUSH_i  = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        SA_VALID_i = 1'b0;
        SA_FLUSH_i = 1'b0;
        SA_READY_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("end_drained", DW'(q.size()), '0);
        chk("end_valid", DW'(SA_VALID_o), DW'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
